// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, instruction field positions,
// opcode/funct constants and flag bit indices.
package alu_pkg;

    localparam int DATA_W_DEFAULT     = 32;
    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int INSTR_W            = 32;

    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;

    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 0;

    function automatic logic [RS_MSB-RS_LSB:0] rs_of(input logic [INSTR_W-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [RT_MSB-RT_LSB:0] rt_of(input logic [INSTR_W-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/alu_opstage_regfile.sv
// 2-read / 1-write GPR file with combinational reads, write-through bypass
// and register 0 hardwired to zero.
module alu_opstage_regfile
    import alu_pkg::*;
#(
    parameter int DW = DATA_W_DEFAULT,
    parameter int AW = REG_ADDR_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_a_addr,
    output logic [DW-1:0] rd_a_data,
    input  logic [AW-1:0] rd_b_addr,
    output logic [DW-1:0] rd_b_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);

    localparam int N_REGS = 2 ** AW;

    logic [DW-1:0] mem_q [N_REGS];
    logic [DW-1:0] mem_d [N_REGS];

    always_comb begin
        mem_d = mem_q;
        if (wb_en && wb_addr != '0) begin
            mem_d[wb_addr] = wb_data;
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // A write landing in the same cycle as the read is forwarded.
    assign rd_a_data = (rd_a_addr == '0) ? '0 :
                       (wb_en && wb_addr == rd_a_addr) ? wb_data : mem_q[rd_a_addr];
    assign rd_b_data = (rd_b_addr == '0) ? '0 :
                       (wb_en && wb_addr == rd_b_addr) ? wb_data : mem_q[rd_b_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: reads rs/rt from the GPR file and
// registers the bundle. ALU_OPSTAGE_SKID_EN adds a skid entry and a registered in_ready.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSTR_W-1:0]    out_instr,
    output logic [DATA_W-1:0]     out_rega,
    output logic [DATA_W-1:0]     out_regb,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data
);

    function automatic logic [REG_ADDR_W-1:0] src_rs(input logic [INSTR_W-1:0] instr);
        return REG_ADDR_W'(rs_of(instr));
    endfunction

    function automatic logic [REG_ADDR_W-1:0] src_rt(input logic [INSTR_W-1:0] instr);
        return REG_ADDR_W'(rt_of(instr));
    endfunction

    // A held operand tracks writebacks to its source register.
    function automatic logic [DATA_W-1:0] refresh(
        input logic [REG_ADDR_W-1:0] src,
        input logic [DATA_W-1:0]     cur,
        input logic                  en,
        input logic [REG_ADDR_W-1:0] addr,
        input logic [DATA_W-1:0]     data
    );
        return (en && addr == src && src != '0) ? data : cur;
    endfunction

    logic [DATA_W-1:0] rd_a_data;
    logic [DATA_W-1:0] rd_b_data;
    logic              accept;

    alu_opstage_regfile #(
        .DW (DATA_W),
        .AW (REG_ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_a_addr (src_rs(in_instr)),
        .rd_a_data (rd_a_data),
        .rd_b_addr (src_rt(in_instr)),
        .rd_b_data (rd_b_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [DATA_W-1:0]  out_rega_q,  out_rega_d;
    logic [DATA_W-1:0]  out_regb_q,  out_regb_d;

    assign accept = in_valid && in_ready;

`ifdef ALU_OPSTAGE_SKID_EN
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_W-1:0]  skid_rega_q,  skid_rega_d;
    logic [DATA_W-1:0]  skid_regb_q,  skid_regb_d;
    logic               in_ready_q,   in_ready_d;

    assign in_ready = in_ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_rega_d   = refresh(src_rs(out_instr_q), out_rega_q, wb_en, wb_addr, wb_data);
        out_regb_d   = refresh(src_rt(out_instr_q), out_regb_q, wb_en, wb_addr, wb_data);
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_rega_d  = refresh(src_rs(skid_instr_q), skid_rega_q, wb_en, wb_addr, wb_data);
        skid_regb_d  = refresh(src_rt(skid_instr_q), skid_regb_q, wb_en, wb_addr, wb_data);

        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                // in_ready is low while the skid is full, so no accept can collide here.
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_rega_d   = skid_rega_d;
                out_regb_d   = skid_regb_d;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_instr_d = in_instr;
                out_rega_d  = rd_a_data;
                out_regb_d  = rd_b_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_instr_d = in_instr;
            skid_rega_d  = rd_a_data;
            skid_regb_d  = rd_b_data;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_rega_q  <= '0;
            skid_regb_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_rega_q  <= skid_rega_d;
            skid_regb_q  <= skid_regb_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_rega_d  = refresh(src_rs(out_instr_q), out_rega_q, wb_en, wb_addr, wb_data);
        out_regb_d  = refresh(src_rt(out_instr_q), out_regb_q, wb_en, wb_addr, wb_data);
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = in_instr;
            out_rega_d  = rd_a_data;
            out_regb_d  = rd_b_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_rega_q  <= '0;
            out_regb_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_rega_q  <= out_rega_d;
            out_regb_q  <= out_regb_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_rega  = out_rega_q;
    assign out_regb  = out_regb_q;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the ALU.
- Accepts a 32-bit MIPS instruction over a valid/ready handshake and reads GPR[rs] and GPR[rt] from an internal 32x32 register file.
- Presents instruction, regA and regB, registered, to the ALU inputs.
- A writeback port from downstream updates the register file, with same-cycle bypass and refresh of stalled operands.

Parameters:
- DATA_W, 32, register and operand width.
- REG_ADDR_W, 5, register index width; the file holds 2**REG_ADDR_W entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- out_valid  out  1  output bundle valid for the ALU.
- out_ready  in  1  downstream accepts the bundle.
- out_instr  out  32  instruction to the ALU instruction input.
- out_rega  out  DATA_W  GPR[in_instr[25:21]] (rs), to ALU regA.
- out_regb  out  DATA_W  GPR[in_instr[20:16]] (rt), to ALU regB.
- wb_en  in  1  register write enable.
- wb_addr  in  REG_ADDR_W  write index.
- wb_data  in  DATA_W  write data.

Behaviour:
- Reset (async assert, sync release): all registers cleared to 0; out_valid=0, out_instr=0, out_rega=0, out_regb=0; in_ready=1 one cycle after release.
- Register 0 is hardwired to 0. Writes to index 0 are dropped; reads of index 0 return 0.
- Handshake (base build):
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
- Latency: 1 cycle. An instruction accepted at edge N is valid on the outputs after edge N and is held stable until the out-transfer.
- Back-to-back: full throughput, one instruction per cycle, when out_ready is held at 1.
- Operand read with write-through: if wb_en && wb_addr==src && src!=0 in the accept cycle, the captured operand is wb_data, not the old file contents.
- Stalled refresh: while out_valid && !out_ready, a wb_en hitting out_instr[25:21] (nonzero) replaces out_rega on the next edge; the same rule applies to out_instr[20:16] and out_regb. This is the only permitted change to held outputs.
- Simultaneous accept and out-transfer: the new bundle replaces the old one in the same edge. No bubble is inserted.
- Writeback is independent of the handshake and is always committed on the edge where wb_en=1.
- Operands are raw register contents; the ALU performs sign and zero extension. Instruction fields are not decoded beyond rs and rt.
- Reset mid-operation: the in-flight bundle is discarded and the register file is cleared.
- No backpressure is applied on writeback; wb_en is honoured every cycle.

Optional Feature:
- Macro: ALU_OPSTAGE_SKID_EN.
- With the macro defined:
  - A 1-entry skid buffer is added, and in_ready becomes a registered signal with no combinational path from out_ready.
  - in_ready drops one cycle after the skid entry fills and rises after it drains.
  - The skid entry also obeys the stalled-refresh rule.
  - Latency stays 1 cycle when there is no stall.
- Without the macro: the combinational in_ready described in Behaviour applies, and there is no skid storage.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W and REG_ADDR_W defaults.
  - Field positions RS_MSB/RS_LSB=25/21, RT_MSB/RT_LSB=20/16, OPCODE 31:26, FUNCT 5:0.
  - Opcode and funct constants shared with the ALU: ADD=6'h20, ADDU=6'h21, ADDI=6'h08, ADDIU=6'h09.
  - Flag bit indices ZERO=2, NEG=1, OVF=0.
- One sub-module: alu_opstage_regfile, a 2-read 1-write register file with combinational reads, write-through bypass and the register-0 rule.
- The handshake, skid buffer and refresh logic live in the top module.

Test Plan:
- Reset, then write 4 to r1 and 5 to r2; instruction 0x00221820 (rs=1, rt=2) -> out_rega=4, out_regb=5, out_instr passed through, 1-cycle latency.
- Write wb r3=0xFFFFFFFC in the same cycle that an instruction with rs=3 is accepted -> out_rega=0xFFFFFFFC (bypass), not the stale 0.
- Hold out_ready=0 with the bundle rs=1 valid, then write wb r1=10 -> out_rega becomes 10 on the next edge, out_valid stays 1, and in_ready=0 (base build).
- Issue wb r0=0x12345678, then an instruction with rs=0, rt=0 -> out_rega=out_regb=0.
- Stream 8 instructions with in_valid=1 and out_ready=1 -> 8 out-transfers in 8 consecutive cycles, in order. Toggling out_ready loses and duplicates nothing.
- Assert rst_n=0 mid-stream -> out_valid=0 immediately (asynchronous), and rereading r1 after release returns 0. With ALU_OPSTAGE_SKID_EN, in_ready shows no same-cycle dependence on out_ready.
